branch_predictor_btb: RTL

//  Produces pred_takenF/pred_targetF for the fetch stage; the ID/EX register carries them to EX as pred_takenE/pred_targetE.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/sat_counter2.sv | 22 ++
 rtl/branch_predictor_btb.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width and branch
// predictor 2-bit counter encodings.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;
  localparam ctr_e CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, next-state only.
// Holds at ST when counting up and at SNT when counting down.
module sat_counter2
  import cpu_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic inc_i,
  output ctr_e ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (1'b1)
      inc_i && (ctr_i != CTR_ST):
        ctr_o = ctr_e'(ctr_i + 2'd1);
      !inc_i && (ctr_i != CTR_SNT):
        ctr_o = ctr_e'(ctr_i - 2'd1);
      default: ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters, trained
// from EX, plus mispredict detection and perf counters.
module branch_predictor_btb
  import cpu_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_F,
  output logic            pred_takenF,
  output logic [XLEN-1:0] pred_targetF,
  input  logic            ex_branch_valid,
  input  logic [XLEN-1:0] pc_E,
  input  logic            taken_E,
  input  logic [XLEN-1:0] target_E,
  input  logic            pred_takenE,
  input  logic [XLEN-1:0] pred_targetE,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  ctr_e               ctr_q    [ENTRIES];
  ctr_e               ctr_d    [ENTRIES];

  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  ctr_e             ctr_nxt;
  logic             unused_pc_lsb;

  assign unused_pc_lsb = ^{pc_F[1:0], pc_E[1:0]};

  assign f_idx = pc_F[IDX_W+1:2];
  assign f_tag = pc_F[31:IDX_W+2];
  assign e_idx = pc_E[IDX_W+1:2];
  assign e_tag = pc_E[31:IDX_W+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  // Outputs are forced quiet while reset is held.
  assign pred_takenF  = reset && f_hit && ctr_q[f_idx][1];
  assign pred_targetF = pred_takenF ? target_q[f_idx] : '0;

  assign mispredict = reset && ex_branch_valid &&
                      ((taken_E != pred_takenE) ||
                       (taken_E && (target_E != pred_targetE)));

  assign redirect_pc = !mispredict ? '0 :
                       taken_E ? target_E : pc_E + 32'd4;

  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;

  sat_counter2 u_ctr (
    .ctr_i (ctr_q[e_idx]),
    .inc_i (taken_E),
    .ctr_o (ctr_nxt)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (ex_branch_valid) begin
      if (e_hit) begin
        ctr_d[e_idx] = ctr_nxt;
        if (taken_E) target_d[e_idx] = target_E;
      end else if (taken_E) begin
        valid_d[e_idx]  = 1'b1;
        tag_d[e_idx]    = e_tag;
        target_d[e_idx] = target_E;
        ctr_d[e_idx]    = CTR_ALLOC;
      end
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 32'd1;
      if (mispredict && (mp_cnt_q != '1))
        mp_cnt_d = mp_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

endmodule
